// File: rtl/layer_mixer_if.sv
// -----------------------------------------------------------------------------
// layer_mixer_if
// Pixel-side bus of the layer mixer: the per-layer pen bus coming in, the
// synchronous palette RAM port, and the resolved pixel going out.
//
//   pen_valid         pen bus carries a pixel this cycle
//   pen_priority      packed priorities, layer i at [i*PRIO_BITS +: PRIO_BITS]
//   pen_palette       packed palette indices, layer i at [i*PAL_BITS +: PAL_BITS]
//   pen_color         packed 8-bit colour codes, 0 = transparent
//   palette_ram_addr  registered palette RAM read address
//   palette_ram_dout  palette RAM data, one cycle after the address
//   dout              resolved 16-bit pixel colour
//   dout_valid        dout holds a pixel
//   dout_layer        winning layer index; all-ones = background
//
// slave  : the mixer side.
// master : the pen source / palette RAM / pixel sink side.
// -----------------------------------------------------------------------------
interface layer_mixer_if #(
  parameter int NUM_LAYERS = 4,
  parameter int PRIO_BITS  = 2,
  parameter int PAL_BITS   = 6,
  parameter int ADDR_WIDTH = 15
);
  localparam int LAYER_W = $clog2(NUM_LAYERS) + 1;

  logic                            pen_valid;
  logic [NUM_LAYERS*PRIO_BITS-1:0] pen_priority;
  logic [NUM_LAYERS*PAL_BITS-1:0]  pen_palette;
  logic [NUM_LAYERS*8-1:0]         pen_color;
  logic [ADDR_WIDTH-1:0]           palette_ram_addr;
  logic [15:0]                     palette_ram_dout;
  logic [15:0]                     dout;
  logic                            dout_valid;
  logic [LAYER_W-1:0]              dout_layer;

  modport slave (
    input  pen_valid, pen_priority, pen_palette, pen_color, palette_ram_dout,
    output palette_ram_addr, dout, dout_valid, dout_layer
  );

  modport master (
    output pen_valid, pen_priority, pen_palette, pen_color, palette_ram_dout,
    input  palette_ram_addr, dout, dout_valid, dout_layer
  );
endinterface

// File: rtl/layer_mixer.sv
// -----------------------------------------------------------------------------
// layer_mixer
// Four-stage priority mixer. Each cycle it picks the opaque layer with the
// highest priority (ties to the higher layer index), forms its palette RAM
// address from the per-layer bank/granularity, reads the palette RAM and
// returns the colour.
//
//   stage 1  register pen bus + pen_valid
//   stage 2  resolve winner, register palette_ram_addr, layer tag, valid
//   stage 3  RAM read in flight; carry tag + valid
//   stage 4  register palette_ram_dout into dout, plus dout_layer/dout_valid
//
// Ports
//   clock            sole clock, all flops rise on it
//   reset            asynchronous, active-high
//   bus              layer_mixer_if.slave (pen bus, palette RAM, pixel out)
//   frame_start      one-cycle pulse; commits the shadow cfg_* values
//   cfg_enable       shadow per-layer enable mask
//   cfg_granularity  shadow per-layer mode, 2 bits each: 0=16, 1=64, 2/3=256
//   cfg_bank         shadow per-layer palette bank
//   cfg_bg_addr      shadow background palette address
// -----------------------------------------------------------------------------
module layer_mixer #(
  parameter int NUM_LAYERS = 4,
  parameter int PRIO_BITS  = 2,
  parameter int PAL_BITS   = 6,
  parameter int BANK_BITS  = 2,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                            clock,
  input  logic                            reset,
  layer_mixer_if.slave                    bus,
  input  logic                            frame_start,
  input  logic [NUM_LAYERS-1:0]           cfg_enable,
  input  logic [NUM_LAYERS*2-1:0]         cfg_granularity,
  input  logic [NUM_LAYERS*BANK_BITS-1:0] cfg_bank,
  input  logic [ADDR_WIDTH-1:0]           cfg_bg_addr
);

  localparam int                 LAYER_W = $clog2(NUM_LAYERS) + 1;
  localparam logic [LAYER_W-1:0] BG_TAG  = '1;

  typedef enum logic [1:0] {
    GRAN_16  = 2'd0,
    GRAN_64  = 2'd1,
    GRAN_256 = 2'd2
  } gran_e;

  // ---------------------------------------------------------------------------
  // Active configuration. Loaded at the same edge as frame_start, so the pixel
  // captured into stage 1 on that edge is resolved with the new values one
  // edge later, while the pixel already in stage 1 still sees the old ones.
  // ---------------------------------------------------------------------------
  logic [NUM_LAYERS-1:0]           act_enable;
  logic [NUM_LAYERS*2-1:0]         act_granularity;
  logic [NUM_LAYERS*BANK_BITS-1:0] act_bank;
  logic [ADDR_WIDTH-1:0]           act_bg_addr;

  // NOTE: every clocked block uses non-blocking assignments so that all flops
  // sample their inputs as they were just before the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act_enable      <= '1;
      act_granularity <= {NUM_LAYERS{GRAN_256}};
      act_bank        <= '0;
      act_bg_addr     <= '0;
    end else if (frame_start) begin
      act_enable      <= cfg_enable;
      act_granularity <= cfg_granularity;
      act_bank        <= cfg_bank;
      act_bg_addr     <= cfg_bg_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: pen bus capture
  // ---------------------------------------------------------------------------
  logic                            s1_valid;
  logic [NUM_LAYERS*PRIO_BITS-1:0] s1_priority;
  logic [NUM_LAYERS*PAL_BITS-1:0]  s1_palette;
  logic [NUM_LAYERS*8-1:0]         s1_color;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_priority <= '0;
      s1_palette  <= '0;
      s1_color    <= '0;
    end else begin
      s1_valid    <= bus.pen_valid;
      s1_priority <= bus.pen_priority;
      s1_palette  <= bus.pen_palette;
      s1_color    <= bus.pen_color;
    end
  end

  // ---------------------------------------------------------------------------
  // Winner resolution and address formation
  // ---------------------------------------------------------------------------
  logic                  win_found;
  logic [LAYER_W-1:0]    win_idx;
  logic [PRIO_BITS-1:0]  win_prio;
  logic [BANK_BITS-1:0]  sel_bank;
  logic [PAL_BITS-1:0]   sel_pal;
  logic [7:0]            sel_color;
  logic [1:0]            sel_gran;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [LAYER_W-1:0]    next_tag;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    sel_bank  = '0;
    sel_pal   = '0;
    sel_color = '0;
    sel_gran  = '0;

    // Ascending scan with >= lets a higher index take a priority tie.
    // Opacity looks at all 8 colour bits whatever the granularity.
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (act_enable[i] && (s1_color[i*8 +: 8] != 8'd0) &&
          (!win_found || (s1_priority[i*PRIO_BITS +: PRIO_BITS] >= win_prio))) begin
        win_found = 1'b1;
        win_idx   = LAYER_W'(i);
        win_prio  = s1_priority[i*PRIO_BITS +: PRIO_BITS];
        sel_bank  = act_bank[i*BANK_BITS +: BANK_BITS];
        sel_pal   = s1_palette[i*PAL_BITS +: PAL_BITS];
        sel_color = s1_color[i*8 +: 8];
        sel_gran  = act_granularity[i*2 +: 2];
      end
    end

    // {bank, palette, colour LSBs}; the size cast zero-extends or drops MSBs.
    case (sel_gran)
      GRAN_16: win_addr = ADDR_WIDTH'({sel_bank, sel_pal, sel_color[3:0]});
      GRAN_64: win_addr = ADDR_WIDTH'({sel_bank, sel_pal, sel_color[5:0]});
      default: win_addr = ADDR_WIDTH'({sel_bank, sel_pal, sel_color});
    endcase

    next_addr = win_found ? win_addr : act_bg_addr;
    next_tag  = win_found ? win_idx  : BG_TAG;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: address register (updates every cycle, valid or not)
  // ---------------------------------------------------------------------------
  logic               s2_valid;
  logic [LAYER_W-1:0] s2_tag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid             <= 1'b0;
      s2_tag               <= BG_TAG;
      bus.palette_ram_addr <= '0;
    end else begin
      s2_valid             <= s1_valid;
      s2_tag               <= next_tag;
      bus.palette_ram_addr <= next_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: palette RAM read in flight
  // ---------------------------------------------------------------------------
  logic               s3_valid;
  logic [LAYER_W-1:0] s3_tag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s3_tag   <= BG_TAG;
    end else begin
      s3_valid <= s2_valid;
      s3_tag   <= s2_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: output; colour and tag hold across bubbles
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.dout       <= '0;
      bus.dout_layer <= BG_TAG;
      bus.dout_valid <= 1'b0;
    end else begin
      bus.dout_valid <= s3_valid;
      if (s3_valid) begin
        bus.dout       <= bus.palette_ram_dout;
        bus.dout_layer <= s3_tag;
      end
    end
  end

endmodule

// File: tb/tb_layer_mixer.sv
// -----------------------------------------------------------------------------
// tb_layer_mixer
// Directed table of pixels with hand-computed addresses, a randomized run
// against a behavioural model, and a continuous-stream sequence with a reset
// pulse in the middle. A small synchronous palette RAM model returns a
// known function of the address so dout can be predicted.
// -----------------------------------------------------------------------------
module tb_layer_mixer;

  localparam int NL   = 4;
  localparam int PB   = 2;
  localparam int PALB = 6;
  localparam int BB   = 2;
  localparam int AW   = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start;
  logic [3:0]  cfg_enable;
  logic [7:0]  cfg_granularity;
  logic [7:0]  cfg_bank;
  logic [14:0] cfg_bg_addr;

  layer_mixer_if #(.NUM_LAYERS(NL), .PRIO_BITS(PB), .PAL_BITS(PALB), .ADDR_WIDTH(AW)) pix_if ();

  layer_mixer #(
    .NUM_LAYERS(NL), .PRIO_BITS(PB), .PAL_BITS(PALB), .BANK_BITS(BB), .ADDR_WIDTH(AW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (pix_if),
    .frame_start     (frame_start),
    .cfg_enable      (cfg_enable),
    .cfg_granularity (cfg_granularity),
    .cfg_bank        (cfg_bank),
    .cfg_bg_addr     (cfg_bg_addr)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] ram_word(input logic [AW-1:0] a);
    return ({1'b0, a} * 16'd5) ^ 16'hC3A5;
  endfunction

  // Synchronous-read palette RAM
  always @(posedge clock) pix_if.palette_ram_dout <= ram_word(pix_if.palette_ram_addr);

  typedef struct {
    bit        pv;
    bit [7:0]  prio;
    bit [23:0] pal;
    bit [31:0] col;
    bit        fs;
    bit [3:0]  en;
    bit [7:0]  gran;
    bit [7:0]  bank;
    bit [14:0] bg;
    int        exp_addr;
    int        exp_layer;
  } vec_t;

  typedef struct {
    bit v;
    int addr;
    int layer;
  } exp_t;

  exp_t        exp_q[$];
  int          m_en[NL];
  int          m_gran[NL];
  int          m_bank[NL];
  int          m_bg;
  logic [15:0] m_dout;
  logic [2:0]  m_layer;
  int          n_vec  = 0;
  int          n_fail = 0;
  vec_t        tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit pv, input bit [7:0] prio, input bit [23:0] pal,
                              input bit [31:0] col, input bit fs, input bit [3:0] en,
                              input bit [7:0] gran, input bit [7:0] bank, input bit [14:0] bg,
                              input int exp_addr, input int exp_layer);
    vec_t v;
    v.pv = pv; v.prio = prio; v.pal = pal; v.col = col; v.fs = fs; v.en = en;
    v.gran = gran; v.bank = bank; v.bg = bg; v.exp_addr = exp_addr; v.exp_layer = exp_layer;
    return v;
  endfunction

  // Model state after a reset: defaults, three empty pipeline slots whose
  // address is the reset background address.
  task automatic reset_model();
    exp_t e;
    for (int i = 0; i < NL; i++) begin
      m_en[i] = 1; m_gran[i] = 2; m_bank[i] = 0;
    end
    m_bg    = 0;
    m_dout  = 16'h0000;
    m_layer = 3'b111;
    exp_q.delete();
    e.v = 1'b0; e.addr = 0; e.layer = 7;
    repeat (3) exp_q.push_back(e);
  endtask

  // Winner = largest (priority * NL + index) among opaque enabled layers.
  function automatic void model(input bit [7:0] prio, input bit [23:0] pal, input bit [31:0] col,
                                output int addr, output int layer);
    int best_key, k, c, p;
    best_key = -1;
    layer    = 7;
    addr     = m_bg;
    for (int i = 0; i < NL; i++) begin
      if (m_en[i] != 0 && col[8*i +: 8] != 8'd0) begin
        k = int'(prio[2*i +: 2]) * NL + i;
        if (k > best_key) begin
          best_key = k;
          layer    = i;
        end
      end
    end
    if (layer != 7) begin
      c = (m_gran[layer] == 0) ? 4 : (m_gran[layer] == 1) ? 6 : 8;
      p = int'(pal[6*layer +: 6]);
      addr = ((m_bank[layer] << (6 + c)) + (p << c) + (int'(col[8*layer +: 8]) % (1 << c)))
             % (1 << AW);
    end
  endfunction

  // Called at a falling edge; applies one cycle and checks outputs at the
  // next falling edge.
  task automatic apply(input vec_t v, input bit use_model);
    exp_t e;
    pix_if.pen_valid    = v.pv;
    pix_if.pen_priority = v.prio;
    pix_if.pen_palette  = v.pal;
    pix_if.pen_color    = v.col;
    frame_start         = v.fs;
    cfg_enable          = v.en;
    cfg_granularity     = v.gran;
    cfg_bank            = v.bank;
    cfg_bg_addr         = v.bg;
    if (v.fs) begin
      for (int i = 0; i < NL; i++) begin
        m_en[i]   = int'(v.en[i]);
        m_gran[i] = int'(v.gran[2*i +: 2]);
        m_bank[i] = int'(v.bank[2*i +: 2]);
      end
      m_bg = int'(v.bg);
    end
    e.v = v.pv;
    if (use_model) model(v.prio, v.pal, v.col, e.addr, e.layer);
    else begin
      e.addr  = v.exp_addr;
      e.layer = v.exp_layer;
    end
    @(posedge clock);
    exp_q.push_back(e);
    @(negedge clock);
    check("palette_ram_addr", 32'(pix_if.palette_ram_addr), 32'(exp_q[exp_q.size()-2].addr));
    e = exp_q.pop_front();
    if (e.v) begin
      m_dout  = ram_word(AW'(e.addr));
      m_layer = 3'(e.layer);
    end
    check("dout_valid", 32'(pix_if.dout_valid), 32'(e.v));
    check("dout",       32'(pix_if.dout),       32'(m_dout));
    check("dout_layer", 32'(pix_if.dout_layer), 32'(m_layer));
  endtask

  function automatic vec_t rand_vec(input bit allow_fs, input bit force_valid);
    vec_t v;
    v.pv   = force_valid || ($urandom_range(0, 3) != 0);
    v.prio = 8'($urandom);
    v.pal  = 24'($urandom);
    v.col  = $urandom;
    for (int i = 0; i < NL; i++)
      if ($urandom_range(0, 9) < 4) v.col[8*i +: 8] = 8'h00;
    v.fs   = allow_fs && ($urandom_range(0, 9) == 0);
    v.en   = 4'($urandom);
    v.gran = 8'($urandom);
    v.bank = 8'($urandom);
    v.bg   = 15'($urandom);
    v.exp_addr  = 0;
    v.exp_layer = 0;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " addr"},       32'(pix_if.palette_ram_addr), 32'h0);
    check({tag, " dout"},       32'(pix_if.dout),             32'h0);
    check({tag, " dout_valid"}, 32'(pix_if.dout_valid),       32'h0);
    check({tag, " dout_layer"}, 32'(pix_if.dout_layer),       32'h7);
  endtask

  initial begin
    pix_if.pen_valid    = 1'b0;
    pix_if.pen_priority = '0;
    pix_if.pen_palette  = '0;
    pix_if.pen_color    = '0;
    frame_start         = 1'b0;
    cfg_enable          = '0;
    cfg_granularity     = '0;
    cfg_bank            = '0;
    cfg_bg_addr         = '0;

    //             pv prio   pal         col           fs en    gran   bank   bg        addr     layer
    tbl[0] = mk(1, 8'h28, 24'h002040, 32'h00221100, 0, 4'hF, 8'hAA, 8'h00, 15'h0000, 'h0222, 2); // tie 1 vs 2
    tbl[1] = mk(1, 8'h00, 24'h000000, 32'h00000000, 1, 4'hF, 8'hAA, 8'h00, 15'h3F00, 'h3F00, 7); // background
    tbl[2] = mk(1, 8'h04, 24'h000140, 32'h0000AB00, 1, 4'hF, 8'hA2, 8'h04, 15'h3F00, 'h045B, 1); // 16-colour
    tbl[3] = mk(1, 8'hC1, 24'hFC0010, 32'h80000001, 0, 4'hF, 8'hA2, 8'h04, 15'h3F00, 'h3F80, 3); // old cfg
    tbl[4] = mk(1, 8'hC1, 24'hFC0010, 32'h80000001, 1, 4'h7, 8'hA2, 8'h04, 15'h3F00, 'h1001, 0); // new cfg
    tbl[5] = mk(1, 8'hFF, 24'h000081, 32'h00003C05, 0, 4'h7, 8'hA2, 8'h04, 15'h3F00, 'h042C, 1); // tie 0 vs 1
    tbl[6] = mk(0, 8'h00, 24'h000000, 32'h00000000, 0, 4'h7, 8'hA2, 8'h04, 15'h3F00, 'h3F00, 7); // bubble
    tbl[7] = mk(1, 8'h00, 24'h03F000, 32'h00FF0000, 1, 4'hF, 8'h55, 8'hFF, 15'h0123, 'h3FFF, 2); // 64-colour
    tbl[8] = mk(1, 8'h00, 24'hA80000, 32'hC3000000, 1, 4'hF, 8'hAA, 8'hFF, 15'h0123, 'h6AC3, 3); // truncation
    tbl[9] = mk(1, 8'h00, 24'h000000, 32'h01010101, 1, 4'h0, 8'hAA, 8'hFF, 15'h0123, 'h0123, 7); // all disabled

    // Power-on reset
    reset_model();
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) apply(tbl[i], 1'b0);

    // Randomized traffic with occasional config commits
    for (int i = 0; i < 300; i++) apply(rand_vec(1'b1, 1'b0), 1'b1);

    // Continuous stream with a reset pulse at cycle 50
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        reset = 1'b1;
        #1;
        check_reset_outputs("mid reset");
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs("mid reset held");
        reset = 1'b0;
        reset_model();
      end
      apply(rand_vec(1'b0, 1'b1), 1'b1);
    end

    // Drain
    for (int i = 0; i < 4; i++) apply(rand_vec(1'b0, 1'b0), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_mixer.md
LAYER_MIXER -- requirements
Module: layer_mixer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, pen sources; index 0 = sprite, 1..N-1 = tilemap layers.
REQ-002 SHALL have parameter PRIO_BITS, default 2, priority width per pen.
REQ-003 SHALL have parameter PAL_BITS, default 6, palette index width per pen.
REQ-004 SHALL have parameter BANK_BITS, default 2, palette bank width per layer.
REQ-005 SHALL have parameter ADDR_WIDTH, default 15, palette RAM address width.
REQ-006 SHALL have port clock  in  1  sole clock; all flops rise on it.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port pen_valid  in  1  pen bus carries a pixel this cycle.
REQ-009 SHALL have port pen_priority  in  NUM_LAYERS*PRIO_BITS  packed priorities, layer i at [i*PRIO_BITS +: PRIO_BITS].
REQ-010 SHALL have port pen_palette  in  NUM_LAYERS*PAL_BITS  packed palette indices.
REQ-011 SHALL have port pen_color  in  NUM_LAYERS*8  packed colour codes; 0 = transparent.
REQ-012 SHALL have port frame_start  in  1  one-cycle pulse; commits shadow config.
REQ-013 SHALL have port cfg_enable  in  NUM_LAYERS  shadow per-layer enable mask.
REQ-014 SHALL have port cfg_granularity  in  NUM_LAYERS*2  shadow per-layer mode: 0=16, 1=64, 2/3=256 colours.
REQ-015 SHALL have port cfg_bank  in  NUM_LAYERS*BANK_BITS  shadow per-layer palette bank.
REQ-016 SHALL have port cfg_bg_addr  in  ADDR_WIDTH  shadow background palette address.
REQ-017 SHALL have port palette_ram_addr  out  ADDR_WIDTH  registered sync-read address.
REQ-018 SHALL have port palette_ram_dout  in  16  RAM data, one cycle after address.
REQ-019 SHALL have port dout  out  16  registered pixel colour.
REQ-020 SHALL have port dout_valid  out  1  dout holds a pixel.
REQ-021 SHALL have port dout_layer  out  log2(NUM_LAYERS)+1  winning layer; all-ones = background.

Function
REQ-022 SHALL hold active config registers (enable, granularity, bank, bg_addr) loaded from cfg_* at any edge with frame_start=1; otherwise unchanged.
REQ-023 Stage 1 SHALL register pen bus and pen_valid at every edge.
REQ-024 Layer i SHALL be opaque iff active enable[i]=1 and pen_color[i]!=0 (full 8 bits, independent of granularity).
REQ-025 Winner SHALL be the opaque layer with highest priority value; ties go to the higher layer index.
REQ-026 If no layer opaque, address SHALL be active bg_addr and layer tag all-ones.
REQ-027 Address for winner SHALL be {bank, palette, color[c-1:0]}, c=4/6/8 per granularity, zero-extended or truncated (MSBs dropped) to ADDR_WIDTH.
REQ-028 Stage 2 SHALL register palette_ram_addr, layer tag and valid from stage-1 contents using active config.
REQ-029 Stage 3 SHALL register the tag and valid only (RAM read in flight).
REQ-030 Stage 4 SHALL register palette_ram_dout into dout, plus dout_layer and dout_valid; latency pen_valid edge k -> dout_valid at edge k+3.
REQ-031 Pixel sampled at same edge as frame_start SHALL use the new config; pixel sampled one edge earlier SHALL use the old config.
REQ-032 With pen_valid=0, address stage SHALL still update, but dout and dout_layer SHALL hold and dout_valid SHALL be 0.
REQ-033 Back-to-back pen_valid SHALL produce one dout per cycle, no bubbles.

Reset
REQ-034 On reset: all valid flags 0, palette_ram_addr 0, dout 0, dout_layer all-ones, active enable all-ones, granularity 2, banks 0, bg_addr 0.
REQ-035 Reset assertion mid-pipeline SHALL discard in-flight pixels; no dout_valid until three edges after first post-reset pen_valid.

Verification
REQ-036 Layers 1,2 opaque, prio 2 and 2 -> layer 2 wins; dout_layer=2, dout_valid at k+3.
REQ-037 All colours 0, bg_addr=0x3F00 committed -> palette_ram_addr=0x3F00, dout_layer all-ones.
REQ-038 Layer 1 gran=0, bank=1, palette=0x05, color=0xAB -> address 0x045B.
REQ-039 frame_start with cfg_enable clearing winner layer 3 -> same-edge pixel resolves to next-best layer; previous pixel still layer 3.
REQ-040 Continuous pen_valid 100 cycles, reset pulsed at cycle 50 -> dout 0, valid 0 immediately; valid resumes 3 edges after post-reset pixel.
